// File: rtl/stack_pkg.sv
// Shared types and constants for the stack sequencing controller and its arbiter.
package stack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;
  localparam logic ID_A    = 1'b0;
  localparam logic ID_B    = 1'b1;

  // A push needs room, a pop needs something to take.
  function automatic logic op_legal(input logic op, input logic is_full, input logic is_empty);
    logic ok;
    if (op == OP_PUSH) begin
      ok = !is_full;
    end else begin
      ok = !is_empty;
    end
    return ok;
  endfunction

endpackage

// File: rtl/stack_arb.sv
// Two-way requester arbiter. STACK_CTRL_RR_EN selects round-robin; otherwise A has fixed priority.
module stack_arb
  import stack_pkg::*;
(
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic en_i,
  input  logic last_gnt_i,
  output logic win_id_o
);

`ifdef STACK_CTRL_RR_EN
  // On contention the requester that did not win last time goes first.
  always_comb begin
    win_id_o = ID_A;
    if (en_i) begin
      if (req_a_i && req_b_i) begin
        win_id_o = (last_gnt_i == ID_A) ? ID_B : ID_A;
      end else if (req_b_i) begin
        win_id_o = ID_B;
      end else begin
        win_id_o = ID_A;
      end
    end else begin
      win_id_o = ID_A;
    end
  end
`else
  logic unused_last_s;
  assign unused_last_s = last_gnt_i;

  // A wins whenever it asks; B only when alone.
  always_comb begin
    win_id_o = ID_A;
    if (en_i && !req_a_i && req_b_i) begin
      win_id_o = ID_B;
    end else begin
      win_id_o = ID_A;
    end
  end
`endif

endmodule

// File: rtl/stack_ctrl.sv
// Push/pop sequencer for one LIFO: IDLE -> EXEC -> RESP per operation.
// Arbitration mode is chosen by the STACK_CTRL_RR_EN macro inside stack_arb.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             req_a,
  input  logic             req_b,
  input  logic             op_a,
  input  logic             op_b,
  input  logic [WIDTH-1:0] wdata_a,
  input  logic [WIDTH-1:0] wdata_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic             rsp_err,
  output logic [WIDTH-1:0] rsp_data,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [PTR_W-1:0] stk_ptr,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout,
  output logic             full,
  output logic             empty,
  output logic [PTR_W-1:0] count
);

  localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] ONE_C   = PTR_W'(1);
  localparam logic [PTR_W-1:0] ZERO_C  = PTR_W'(0);

  state_e           state_q, state_d;
  logic [PTR_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             last_q, last_d;
  logic             gnt_a_q, gnt_a_d;
  logic             gnt_b_q, gnt_b_d;
  logic             push_q, push_d;
  logic             pop_q, pop_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_pop_q, rsp_pop_d;

  logic             arb_en_s;
  logic             win_id_s;
  logic             accept_s;
  logic             sel_op_s;
  logic [WIDTH-1:0] sel_data_s;
  logic             legal_s;

  assign arb_en_s = (state_q == IDLE) && !clr;
  assign accept_s = arb_en_s && (req_a || req_b);

  stack_arb u_arb (
    .req_a_i   (req_a),
    .req_b_i   (req_b),
    .en_i      (arb_en_s),
    .last_gnt_i(last_q),
    .win_id_o  (win_id_s)
  );

  assign sel_op_s   = (win_id_s == ID_B) ? op_b : op_a;
  assign sel_data_s = (win_id_s == ID_B) ? wdata_b : wdata_a;
  assign legal_s    = op_legal(sel_op_s, full_q, empty_q);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a flush keeps the FSM in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = IDLE;
        end else if (req_a || req_b) begin
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values. Legality is decided at acceptance, so EXEC
  // strobes and RESP status come straight out of registers.
  always_comb begin
    count_d     = count_q;
    last_d      = last_q;
    gnt_a_d     = 1'b0;
    gnt_b_d     = 1'b0;
    push_d      = 1'b0;
    pop_d       = 1'b0;
    din_d       = {WIDTH{1'b0}};
    rsp_valid_d = 1'b0;
    rsp_id_d    = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_pop_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr) begin
          count_d = ZERO_C;
        end else if (accept_s) begin
          last_d  = win_id_s;
          gnt_a_d = (win_id_s == ID_A);
          gnt_b_d = (win_id_s == ID_B);
          push_d  = legal_s && (sel_op_s == OP_PUSH);
          pop_d   = legal_s && (sel_op_s == OP_POP);
          din_d   = (legal_s && (sel_op_s == OP_PUSH)) ? sel_data_s : {WIDTH{1'b0}};
        end else begin
          count_d = count_q;
        end
      end
      EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = gnt_b_q ? ID_B : ID_A;
        rsp_err_d   = !(push_q || pop_q);
        rsp_pop_d   = pop_q;
        if (push_q && (count_q < DEPTH_C)) begin
          count_d = count_q + ONE_C;
        end else if (pop_q && (count_q > ZERO_C)) begin
          count_d = count_q - ONE_C;
        end else begin
          count_d = count_q;
        end
      end
      RESP: begin
        count_d = count_q;
      end
      default: begin
        count_d = count_q;
      end
    endcase
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == ZERO_C);
  end

  // Registered outputs, count and round-robin history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= ZERO_C;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      last_q      <= ID_B;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      din_q       <= {WIDTH{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_pop_q   <= 1'b0;
    end else begin
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      last_q      <= last_d;
      gnt_a_q     <= gnt_a_d;
      gnt_b_q     <= gnt_b_d;
      push_q      <= push_d;
      pop_q       <= pop_d;
      din_q       <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      rsp_pop_q   <= rsp_pop_d;
    end
  end

  assign gnt_a     = gnt_a_q;
  assign gnt_b     = gnt_b_q;
  assign stk_push  = push_q;
  assign stk_pop   = pop_q;
  assign stk_din   = din_q;
  assign stk_ptr   = count_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  // Pop data is read by the stack at the EXEC edge, so it is passed through in RESP.
  assign rsp_data  = rsp_pop_q ? stk_dout : {WIDTH{1'b0}};
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: a queue-based reference checked every cycle plus directed literal checks.
module tb_stack_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       req_a = 1'b0, req_b = 1'b0, op_a = 1'b0, op_b = 1'b0;
  logic [7:0] wdata_a = 8'h00, wdata_b = 8'h00;
  logic       gnt_a, gnt_b, rsp_valid, rsp_id, rsp_err;
  logic [7:0] rsp_data, stk_din;
  logic [7:0] stk_dout = 8'h00;
  logic       stk_push, stk_pop, full, empty;
  logic [2:0] stk_ptr, count;

  int total = 0;
  int bad = 0;

  stack_ctrl #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_ptr(stk_ptr), .stk_din(stk_din),
    .stk_dout(stk_dout), .full(full), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  // Stand-in for the stack datapath.
  logic [7:0] mem [4];
  always @(posedge clk) begin
    if (stk_push && stk_ptr < 3'd4) mem[stk_ptr[1:0]] <= stk_din;
    if (stk_pop && stk_ptr != 3'd0) stk_dout <= mem[2'(stk_ptr - 3'd1)];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a queue as the stack, plus where the current transaction is in its 3-cycle life.
  int         m_ph = 0;
  logic       m_id = 1'b0, m_op = 1'b0, m_legal = 1'b0, m_last = 1'b1;
  logic [7:0] m_data = 8'h00, m_pop = 8'h00;
  logic [7:0] m_q [$];

  function automatic logic pick(input logic a, input logic b, input logic last);
`ifdef STACK_CTRL_RR_EN
    if (a && b) return !last;
`else
    if (a && b) return 1'b0;
`endif
    return a ? 1'b0 : 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= 0;
      m_last <= 1'b1;
      m_q.delete();
    end else if (m_ph == 0) begin
      if (clr) m_q.delete();
      else if (req_a || req_b) begin
        m_id    <= pick(req_a, req_b, m_last);
        m_last  <= pick(req_a, req_b, m_last);
        m_op    <= pick(req_a, req_b, m_last) ? op_b : op_a;
        m_data  <= pick(req_a, req_b, m_last) ? wdata_b : wdata_a;
        m_legal <= (pick(req_a, req_b, m_last) ? op_b : op_a) ? (m_q.size() < 4) : (m_q.size() > 0);
        m_ph    <= 1;
      end
    end else if (m_ph == 1) begin
      if (m_legal && m_op) m_q.push_back(m_data);
      if (m_legal && !m_op) begin
        m_pop <= m_q[m_q.size()-1];
        void'(m_q.pop_back());
      end
      m_ph <= 2;
    end else begin
      m_ph <= 0;
    end
  end

  // Every-cycle comparison against the reference.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("gnt_a",     32'(gnt_a),     32'(m_ph == 1 && m_id == 1'b0));
      chk("gnt_b",     32'(gnt_b),     32'(m_ph == 1 && m_id == 1'b1));
      chk("stk_push",  32'(stk_push),  32'(m_ph == 1 && m_op && m_legal));
      chk("stk_pop",   32'(stk_pop),   32'(m_ph == 1 && !m_op && m_legal));
      chk("stk_din",   32'(stk_din),   (m_ph == 1 && m_op && m_legal) ? 32'(m_data) : 32'd0);
      chk("rsp_valid", 32'(rsp_valid), 32'(m_ph == 2));
      chk("rsp_id",    32'(rsp_id),    (m_ph == 2) ? 32'(m_id) : 32'd0);
      chk("rsp_err",   32'(rsp_err),   32'(m_ph == 2 && !m_legal));
      chk("rsp_data",  32'(rsp_data),  (m_ph == 2 && !m_op && m_legal) ? 32'(m_pop) : 32'd0);
      chk("count",     32'(count),     32'(m_q.size()));
      chk("stk_ptr",   32'(stk_ptr),   32'(m_q.size()));
      chk("full",      32'(full),      32'(m_q.size() == 4));
      chk("empty",     32'(empty),     32'(m_q.size() == 0));
    end
  end

  task automatic do_op(input logic who, input logic op, input logic [7:0] d,
                       output logic [7:0] rd, output logic rerr, output logic rid);
    bit got = 0;
    @(posedge clk); #1;
    if (who) begin req_b = 1'b1; op_b = op; wdata_b = d; end
    else     begin req_a = 1'b1; op_a = op; wdata_a = d; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (who ? gnt_b : gnt_a) got = 1;
    end
    chk("grant_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    req_a = 1'b0; req_b = 1'b0;
    @(negedge clk);
    chk("rsp_strobe", 32'(rsp_valid), 32'd1);
    rd = rsp_data; rerr = rsp_err; rid = rsp_id;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; clr = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  logic [7:0] rd;
  logic       re, ri;
  logic [7:0] pops [3];
  logic       seq [4];
  int         n;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values.
    @(negedge clk);
    chk("rst_gnt",   32'({gnt_a, gnt_b}), 32'd0);
    chk("rst_rsp",   32'({rsp_valid, rsp_id, rsp_err, rsp_data}), 32'd0);
    chk("rst_stk",   32'({stk_push, stk_pop, stk_ptr, stk_din}), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_flags", 32'({full, empty}), 32'd1);
    @(posedge clk); #1; rst_n = 1'b1;

    // A pushes three items.
    do_op(1'b0, 1'b1, 8'h11, rd, re, ri); chk("push1_err", 32'({re, ri}), 32'd0);
    do_op(1'b0, 1'b1, 8'h22, rd, re, ri); chk("push2_err", 32'({re, ri}), 32'd0);
    do_op(1'b0, 1'b1, 8'h33, rd, re, ri); chk("push3_err", 32'({re, ri}), 32'd0);
    chk("count3", 32'(count), 32'd3);
    chk("not_empty", 32'(empty), 32'd0);

    // B pops them back in reverse order.
    for (int i = 0; i < 3; i++) begin
      do_op(1'b1, 1'b0, 8'h00, rd, re, ri);
      pops[i] = rd;
      chk("pop_id", 32'(ri), 32'd1);
    end
    chk("pop0", 32'(pops[0]), 32'h33);
    chk("pop1", 32'(pops[1]), 32'h22);
    chk("pop2", 32'(pops[2]), 32'h11);
    chk("empty_after_pops", 32'(empty), 32'd1);

    // Pop on empty.
    do_op(1'b1, 1'b0, 8'h00, rd, re, ri);
    chk("underflow_err", 32'(re), 32'd1);
    chk("underflow_data", 32'(rd), 32'd0);
    chk("underflow_count", 32'(count), 32'd0);

    // Overflow on the fifth push, then pop the top.
    for (int i = 1; i <= 5; i++) begin
      do_op(1'b0, 1'b1, 8'(i), rd, re, ri);
      chk("fill_err", 32'(re), (i == 5) ? 32'd1 : 32'd0);
    end
    chk("full_flag", 32'(full), 32'd1);
    do_op(1'b0, 1'b0, 8'h00, rd, re, ri);
    chk("pop_after_full", 32'(rd), 32'h04);

    // Contention: both requesters push continuously.
    pulse_reset();
    @(posedge clk); #1;
    req_a = 1'b1; op_a = 1'b1; wdata_a = 8'hA0;
    req_b = 1'b1; op_b = 1'b1; wdata_b = 8'hB0;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (gnt_a) begin seq[n] = 1'b0; n++; end
      else if (gnt_b) begin seq[n] = 1'b1; n++; end
    end
    @(posedge clk); #1;
    req_a = 1'b0; req_b = 1'b0;
    chk("contention_grants", 32'(n), 32'd4);
`ifdef STACK_CTRL_RR_EN
    chk("rr_order", 32'({seq[0], seq[1], seq[2], seq[3]}), 32'b0101);
`else
    chk("fixed_order", 32'({seq[0], seq[1], seq[2], seq[3]}), 32'b0000);
`endif

    // Reset during EXEC of a third push.
    pulse_reset();
    do_op(1'b0, 1'b1, 8'h55, rd, re, ri);
    do_op(1'b0, 1'b1, 8'h66, rd, re, ri);
    @(posedge clk); #1;
    req_a = 1'b1; op_a = 1'b1; wdata_a = 8'h77;
    n = 0;
    for (int i = 0; i < 20 && n == 0; i++) begin
      @(negedge clk);
      if (gnt_a) n = 1;
    end
    chk("abort_grant_seen", 32'(n), 32'd1);
    #2; rst_n = 1'b0; req_a = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
      chk("abort_count", 32'(count), 32'd0);
    end

    // Flush has priority over a simultaneous request.
    do_op(1'b0, 1'b1, 8'h81, rd, re, ri);
    do_op(1'b0, 1'b1, 8'h82, rd, re, ri);
    chk("pre_clr_count", 32'(count), 32'd2);
    @(posedge clk); #1;
    clr = 1'b1; req_a = 1'b1; op_a = 1'b1; wdata_a = 8'h99;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_no_grant", 32'(gnt_a), 32'd0);
    @(negedge clk);
    chk("post_clr_grant", 32'(gnt_a), 32'd1);
    @(posedge clk); #1; req_a = 1'b0;
    @(negedge clk);
    chk("post_clr_rsp", 32'({rsp_valid, rsp_id, rsp_err}), 32'b100);
    @(negedge clk);
    chk("post_clr_count", 32'(count), 32'd1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
